// File: rtl/matmul_pkg.sv
// Shared state encodings and address helpers for the matrix-multiply sequencer.
// The index width of 16 bits covers N up to 16 with headroom.
package matmul_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_WT_A = 3'd2;
    localparam logic [2:0] S_RD_B = 3'd3;
    localparam logic [2:0] S_WT_B = 3'd4;
    localparam logic [2:0] S_MAC  = 3'd5;
    localparam logic [2:0] S_WR_C = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam int unsigned WORD_SHIFT = 2;
    localparam int unsigned IDX_W      = 16;

    // Byte offset of element (row, col) in a row-major n x n word matrix.
    function automatic logic [IDX_W-1:0] idx2off(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col,
                                                 input logic [IDX_W-1:0] n);
        return (row * n + col) << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters for the matrix multiply, producing the A, B and C element
// addresses and end-of-loop flags.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              step_k_i,
    input  logic              step_ij_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [ADDR_W-1:0] base_c_i,
    output logic [ADDR_W-1:0] addr_a_o,
    output logic [ADDR_W-1:0] addr_b_o,
    output logic [ADDR_W-1:0] addr_c_o,
    output logic              last_k_o,
    output logic              last_ij_o
);

    localparam int unsigned   CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] i_q, j_q, k_q;
    logic [CW-1:0] i_d, j_d, k_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clear_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (step_ij_i) begin
            k_d = '0;
            if (j_q == LAST) begin
                j_d = '0;
                i_d = (i_q == LAST) ? '0 : i_q + CW'(1);
            end else begin
                j_d = j_q + CW'(1);
            end
        end else if (step_k_i) begin
            k_d = k_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign addr_a_o  = base_a_i + ADDR_W'(idx2off(IDX_W'(i_q), IDX_W'(k_q), IDX_W'(N)));
    assign addr_b_o  = base_b_i + ADDR_W'(idx2off(IDX_W'(k_q), IDX_W'(j_q), IDX_W'(N)));
    assign addr_c_o  = base_c_i + ADDR_W'(idx2off(IDX_W'(i_q), IDX_W'(j_q), IDX_W'(N)));
    assign last_k_o  = (k_q == LAST);
    assign last_ij_o = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B on data memory: one req/gnt transaction at a time,
// accumulating each dot product and writing C[i][j] when its k loop ends.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic              clear, step_k, step_ij, last_k, last_ij;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c;

    matmul_addr_gen #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (clear),
        .step_k_i  (step_k),
        .step_ij_i (step_ij),
        .base_a_i  (base_a_q),
        .base_b_i  (base_b_q),
        .base_c_i  (base_c_q),
        .addr_a_o  (addr_a),
        .addr_b_o  (addr_b),
        .addr_c_o  (addr_c),
        .last_k_o  (last_k),
        .last_ij_o (last_ij)
    );

    always_comb begin
        state_d  = state_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_c_d = base_c_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        clear    = 1'b0;
        step_k   = 1'b0;
        step_ij  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_RD_A;
                base_a_d = base_a & ALIGN_MASK;
                base_b_d = base_b & ALIGN_MASK;
                base_c_d = base_c & ALIGN_MASK;
                acc_d    = '0;
                clear    = 1'b1;
            end
            S_RD_A: if (mem_gnt) state_d = S_WT_A;
            S_WT_A: if (mem_rvalid) begin
                a_d     = mem_rdata;
                state_d = S_RD_B;
            end
            S_RD_B: if (mem_gnt) state_d = S_WT_B;
            S_WT_B: if (mem_rvalid) begin
                b_d     = mem_rdata;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + a_q * b_q;
                if (last_k) begin
                    state_d = S_WR_C;
                end else begin
                    step_k  = 1'b1;
                    state_d = S_RD_A;
                end
            end
            // step_ij also resets k, so the next element starts its dot product at k=0.
            S_WR_C: if (mem_gnt) begin
                acc_d   = '0;
                step_ij = 1'b1;
                state_d = last_ij ? S_DONE : S_RD_A;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_c_q <= base_c_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
        end
    end

    // Address and data are forced to zero outside request states so idle outputs are all 0.
    always_comb begin
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        mem_req   = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_WR_C);
        mem_we    = (state_q == S_WR_C);
        mem_wdata = (state_q == S_WR_C) ? acc_q : '0;
        case (state_q)
            S_RD_A:  mem_addr = addr_a;
            S_RD_B:  mem_addr = addr_b;
            S_WR_C:  mem_addr = addr_c;
            default: mem_addr = '0;
        endcase
    end

endmodule
